// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Accepts a binary value over valid/ready, produces packed BCD digits plus a
// leading-zero blanking mask for the downstream 7-segment decoders.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = $clog2(BIN_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]     out_blank,
    output logic                  busy
);

    localparam int SR_W = 4 * DIGITS + BIN_W;

    // Leading digits blanked, units digit always shown (value 0 displays "0").
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit digits_ok(input int bw, input int nd);
        longint pow10;
        longint max_val;
        pow10   = 1;
        max_val = (longint'(1) << bw) - 1;
        for (int i = 0; i < nd; i++) begin
            if (pow10 <= max_val) pow10 = pow10 * 10;
        end
        return pow10 > max_val;
    endfunction

    if (!digits_ok(BIN_W, DIGITS)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for BIN_W (need 10^DIGITS > 2^BIN_W-1)");
    end

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    logic [SR_W-1:0]     sr;          // {BCD digits, remaining binary bits}
    logic [CNT_W-1:0]    cnt;         // binary bits still to shift in
    logic [SR_W-1:0]     sr_adj;
    logic [SR_W-1:0]     sr_next;
    logic [4*DIGITS-1:0] bcd_next;
    logic [DIGITS-1:0]   blank_next;
    logic                upper_zero;

    // One double-dabble iteration: +3 on digits >= 5, then shift left by one.
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no latch is inferred.
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[BIN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        sr_next  = sr_adj << 1;
        bcd_next = sr_next[SR_W-1 -: 4*DIGITS];
    end

    // Blank mask from the post-shift BCD: digit i blanks iff it and all above are 0.
    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero    = upper_zero && (bcd_next[4*i +: 4] == 4'd0);
            blank_next[i] = upper_zero;
        end
    end

    // Control FSM with registered handshake/status outputs and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_blank <= BLANK_RST;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= {{(4*DIGITS){1'b0}}, in_bin};
                        cnt      <= CNT_W'(BIN_W);
                        state    <= CONV;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    sr  <= sr_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_bcd   <= bcd_next;
                        out_blank <= blank_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq with default parameters (8-bit, 3 digits).
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bcd;
    logic [2:0]  out_blank;
    logic        busy;

    int n_pass;
    int n_total;

    bin2bcd_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_blank (out_blank),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference BCD by decimal division.
    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference blank mask by magnitude.
    function automatic logic [2:0] ref_blank(input int v);
        return {v < 100, v < 10, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; lat counts edges after the call.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Full transaction: accept v, wait, stall `stall` cycles, capture, hand off.
    task automatic convert(input int v, input int stall,
                           output logic [11:0] bcd, output logic [2:0] blank,
                           output int lat);
        in_valid = 1'b1;
        in_bin   = 8'(v);
        tick();
        in_valid = 1'b0;
        wait_result(lat);
        for (int i = 0; i < stall; i++) tick();
        bcd   = out_bcd;
        blank = out_blank;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_total += 5;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        if (out_bcd !== 12'h000) $display("FAIL reset_out_bcd got=%h exp=000", out_bcd); else n_pass++;
        if (out_blank !== 3'b110) $display("FAIL reset_out_blank got=%b exp=110", out_blank); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_conversions();
        int          vals [5] = '{255, 0, 7, 42, 100};
        logic [11:0] exp_bcd [5] = '{12'h255, 12'h000, 12'h007, 12'h042, 12'h100};
        logic [2:0]  exp_blk [5] = '{3'b000, 3'b110, 3'b110, 3'b100, 3'b000};
        logic [11:0] bcd;
        logic [2:0]  blank;
        int          lat;
        for (int k = 0; k < 5; k++) begin
            convert(vals[k], 0, bcd, blank, lat);
            n_total += 3;
            if (lat !== 8) $display("FAIL conv_latency v=%0d got=%0d exp=8", vals[k], lat); else n_pass++;
            if (bcd !== exp_bcd[k]) $display("FAIL conv_bcd v=%0d got=%h exp=%h", vals[k], bcd, exp_bcd[k]); else n_pass++;
            if (blank !== exp_blk[k]) $display("FAIL conv_blank v=%0d got=%b exp=%b", vals[k], blank, exp_blk[k]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid = 1'b1;
        in_bin   = 8'd199;
        tick();
        in_valid = 1'b0;
        wait_result(lat);
        n_total++;
        if (lat !== 8) $display("FAIL bp_latency got=%0d exp=8", lat); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total += 3;
            if (out_bcd !== 12'h199) $display("FAIL bp_hold_bcd cyc=%0d got=%h exp=199", i, out_bcd); else n_pass++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); else n_pass++;
            if (out_valid !== 1'b1) $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); else n_pass++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total += 3;
        if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); else n_pass++;
        if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); else n_pass++;
        if (out_bcd !== 12'h199) $display("FAIL bp_retain_bcd got=%h exp=199", out_bcd); else n_pass++;
    endtask

    task automatic test_ignore_in_valid();
        int          lat;
        logic [11:0] bcd;
        logic [2:0]  blank;
        in_valid = 1'b1;
        in_bin   = 8'd250;
        tick();
        in_bin = 8'd13;
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = ~in_valid;
            tick();
            lat++;
        end
        n_total += 3;
        if (lat !== 8) $display("FAIL ign_latency got=%0d exp=8", lat); else n_pass++;
        if (out_bcd !== 12'h250) $display("FAIL ign_bcd got=%h exp=250", out_bcd); else n_pass++;
        if (out_blank !== 3'b000) $display("FAIL ign_blank got=%b exp=000", out_blank); else n_pass++;
        // Hold in_valid high through the output handshake: no same-cycle accept.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total += 2;
        if (busy !== 1'b0) $display("FAIL ign_no_accept_busy got=%b exp=0", busy); else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL ign_idle_in_ready got=%b exp=1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL ign_accept_busy got=%b exp=1", busy); else n_pass++;
        wait_result(lat);
        bcd   = out_bcd;
        blank = out_blank;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total += 3;
        if (lat !== 8) $display("FAIL ign2_latency got=%0d exp=8", lat); else n_pass++;
        if (bcd !== 12'h013) $display("FAIL ign2_bcd got=%h exp=013", bcd); else n_pass++;
        if (blank !== 3'b100) $display("FAIL ign2_blank got=%b exp=100", blank); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [11:0] bcd;
        logic [2:0]  blank;
        int          lat;
        in_valid = 1'b1;
        in_bin   = 8'd128;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_total += 5;
        if (out_valid !== 1'b0) $display("FAIL abort_out_valid got=%b exp=0", out_valid); else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b exp=1", in_ready); else n_pass++;
        if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
        if (out_bcd !== 12'h000) $display("FAIL abort_out_bcd got=%h exp=000", out_bcd); else n_pass++;
        if (out_blank !== 3'b110) $display("FAIL abort_out_blank got=%b exp=110", out_blank); else n_pass++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL abort_stale_valid cyc=%0d got=%b exp=0", i, out_valid); else n_pass++;
        end
        convert(9, 0, bcd, blank, lat);
        n_total += 3;
        if (lat !== 8) $display("FAIL abort_next_latency got=%0d exp=8", lat); else n_pass++;
        if (bcd !== 12'h009) $display("FAIL abort_next_bcd got=%h exp=009", bcd); else n_pass++;
        if (blank !== 3'b110) $display("FAIL abort_next_blank got=%b exp=110", blank); else n_pass++;
    endtask

    task automatic test_sweep();
        logic [11:0] bcd;
        logic [2:0]  blank;
        int          lat;
        for (int v = 0; v < 256; v++) begin
            convert(v, int'($urandom_range(0, 3)), bcd, blank, lat);
            n_total += 3;
            if (lat !== 8) $display("FAIL sweep_latency v=%0d got=%0d exp=8", v, lat); else n_pass++;
            if (bcd !== ref_bcd(v)) $display("FAIL sweep_bcd v=%0d got=%h exp=%h", v, bcd, ref_bcd(v)); else n_pass++;
            if (blank !== ref_blank(v)) $display("FAIL sweep_blank v=%0d got=%b exp=%b", v, blank, ref_blank(v)); else n_pass++;
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        test_reset();
        test_conversions();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_abort();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
